// File: rtl/fpnew_opgroup_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_opgroup_out_arbiter
// Purpose  : Output-side round-robin arbiter for the per-format opgroup
//            slices. One slice is granted per cycle and its result, status,
//            extension bit and tag are registered into a single output stage
//            (1-cycle latency, 1 result/cycle, backpressure-safe).
// Ports    : clk_i / rst_i        clock, asynchronous active-high reset
//            slice_valid_i        per-slice valid
//            slice_ready_o        per-slice accept (grant & stage_en & ~flush)
//            slice_result_i       packed results, slice i at [i*WIDTH +: WIDTH]
//            slice_status_i       packed {NV,DZ,OF,UF,NX}, slice i at [i*5 +: 5]
//            slice_ext_bit_i      per-slice extension bit
//            slice_tag_i          packed tags, slice i at [i*TAG_WIDTH +: TAG_WIDTH]
//            flush_i              drop the held result, accept nothing
//            result_o / status_o / extension_bit_o / tag_o   registered outputs
//            out_valid_o / out_ready_i                       output handshake
//            busy_o               result in flight (== out_valid_o)
//            conflict_cnt_o       saturating contention counter (optional)
// Options  : FPNEW_OUT_ARB_CONFLICT_CNT_EN adds conflict_cnt_o and its counter.
// Revision : 1.0 - initial release
// ============================================================================
module fpnew_opgroup_out_arbiter #(
  parameter int unsigned NUM_SLICES = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned TAG_WIDTH  = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_SLICES-1:0]           slice_valid_i,
  output logic [NUM_SLICES-1:0]           slice_ready_o,
  input  logic [NUM_SLICES*WIDTH-1:0]     slice_result_i,
  input  logic [NUM_SLICES*5-1:0]         slice_status_i,
  input  logic [NUM_SLICES-1:0]           slice_ext_bit_i,
  input  logic [NUM_SLICES*TAG_WIDTH-1:0] slice_tag_i,
  input  logic                            flush_i,
  output logic [WIDTH-1:0]                result_o,
  output logic [4:0]                      status_o,
  output logic                            extension_bit_o,
  output logic [TAG_WIDTH-1:0]            tag_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            busy_o
`ifdef FPNEW_OUT_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]                     conflict_cnt_o
`endif
);

  localparam int unsigned c_PTR_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  logic                   r_valid;
  logic [WIDTH-1:0]       r_result;
  logic [4:0]             r_status;
  logic                   r_ext;
  logic [TAG_WIDTH-1:0]   r_tag;

  logic [c_PTR_W-1:0]     w_rr;
  logic                   w_stage_en;
  logic                   w_accept;
  logic                   w_any;
  logic [c_PTR_W-1:0]     w_off;
  logic [c_PTR_W:0]       w_sum;
  logic [c_PTR_W-1:0]     w_grant_idx;
  logic [c_PTR_W-1:0]     w_rr_next;
  logic [NUM_SLICES-1:0]  w_grant;
  logic [2*NUM_SLICES-1:0] w_dbl;
  logic [NUM_SLICES-1:0]  w_rot;
  logic [WIDTH-1:0]       w_sel_result;
  logic [4:0]             w_sel_status;
  logic                   w_sel_ext;
  logic [TAG_WIDTH-1:0]   w_sel_tag;

  assign w_stage_en = ~r_valid | out_ready_i;
  assign w_accept   = w_any & w_stage_en & ~flush_i;

  // Round-robin search: rotate the valid vector so the current pointer sits
  // at bit 0, take the first set bit, then map the offset back to an index.
  always_comb begin
    w_dbl       = {slice_valid_i, slice_valid_i} >> w_rr;
    w_rot       = w_dbl[NUM_SLICES-1:0];
    w_any       = 1'b0;
    w_off       = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      if (!w_any && w_rot[k]) begin
        w_any = 1'b1;
        w_off = c_PTR_W'(k);
      end
    end
    w_sum = {1'b0, w_rr} + {1'b0, w_off};
    if (w_sum >= (c_PTR_W+1)'(NUM_SLICES)) begin
      w_grant_idx = c_PTR_W'(w_sum - (c_PTR_W+1)'(NUM_SLICES));
    end else begin
      w_grant_idx = w_sum[c_PTR_W-1:0];
    end
    w_rr_next = (w_grant_idx == c_PTR_W'(NUM_SLICES-1)) ? '0 : w_grant_idx + 1'b1;
  end

  // One-hot grant and data mux driven from the winning index.
  always_comb begin
    w_grant      = '0;
    w_sel_result = '0;
    w_sel_status = '0;
    w_sel_ext    = 1'b0;
    w_sel_tag    = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (w_any && (w_grant_idx == c_PTR_W'(i))) begin
        w_grant[i]   = 1'b1;
        w_sel_result = slice_result_i[i*WIDTH +: WIDTH];
        w_sel_status = slice_status_i[i*5 +: 5];
        w_sel_ext    = slice_ext_bit_i[i];
        w_sel_tag    = slice_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // Reset is folded in so upstream never sees a handshake while the stage
  // is being cleared.
  assign slice_ready_o = w_grant & {NUM_SLICES{w_stage_en & ~flush_i & ~rst_i}};

  // Pointer register; a single slice needs no pointer at all.
  generate
    if (NUM_SLICES == 1) begin : g_single_ptr
      assign w_rr = '0;
    end else begin : g_rr_ptr
      logic [c_PTR_W-1:0] r_rr;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_rr <= '0;
        end else if (w_accept) begin
          r_rr <= w_rr_next;
        end
      end
      assign w_rr = r_rr;
    end
  endgenerate

  // Output stage: load on accept, otherwise drain when the stage is free or
  // being flushed (flush wins over a simultaneous out_ready_i).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_status <= '0;
      r_ext    <= 1'b0;
      r_tag    <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_result <= w_sel_result;
      r_status <= w_sel_status;
      r_ext    <= w_sel_ext;
      r_tag    <= w_sel_tag;
    end else if (w_stage_en | flush_i) begin
      r_valid  <= 1'b0;
    end
  end

  assign result_o        = r_result;
  assign status_o        = r_status;
  assign extension_bit_o = r_ext;
  assign tag_o           = r_tag;
  assign out_valid_o     = r_valid;
  assign busy_o          = r_valid;

`ifdef FPNEW_OUT_ARB_CONFLICT_CNT_EN
  // Counts cycles in which at least one valid slice is left waiting.
  logic        w_conflict;
  logic [15:0] r_conflict_cnt;

  assign w_conflict = (($countones(slice_valid_i) >= 2) && w_stage_en) ||
                      ((|slice_valid_i) && !w_stage_en);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpnew_opgroup_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpnew_opgroup_out_arbiter
// Purpose  : Self-checking bench for fpnew_opgroup_out_arbiter (4 slices,
//            32-bit results, 1-bit tag). Vector table plus hand sequences,
//            with a scoreboard for the registered output data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpnew_opgroup_out_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    slice_valid;
  logic [N-1:0]    slice_ready;
  logic [N*W-1:0]  slice_result;
  logic [N*5-1:0]  slice_status;
  logic [N-1:0]    slice_ext;
  logic [N*TW-1:0] slice_tag;
  logic            flush;
  logic [W-1:0]    result;
  logic [4:0]      status;
  logic            ext_bit;
  logic [TW-1:0]   tag;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
`ifdef FPNEW_OUT_ARB_CONFLICT_CNT_EN
  logic [15:0]     conflict_cnt;
`endif

  always #5 clk = ~clk;

  fpnew_opgroup_out_arbiter #(
    .NUM_SLICES (N),
    .WIDTH      (W),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .slice_valid_i   (slice_valid),
    .slice_ready_o   (slice_ready),
    .slice_result_i  (slice_result),
    .slice_status_i  (slice_status),
    .slice_ext_bit_i (slice_ext),
    .slice_tag_i     (slice_tag),
    .flush_i         (flush),
    .result_o        (result),
    .status_o        (status),
    .extension_bit_o (ext_bit),
    .tag_o           (tag),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .busy_o          (busy)
`ifdef FPNEW_OUT_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt_o  (conflict_cnt)
`endif
  );

  typedef struct {
    logic [31:0] result;
    logic [4:0]  status;
    logic        ext;
    logic        tag;
  } exp_t;

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic       flush;
    logic [3:0] exp_ready;
    logic       exp_ov;
  } vec_t;

  exp_t sbq[$];
  int   seq[N];
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[24];

  // Per-slice data stream; slice 2's first item is 3F80_0000 / 00001 / tag 1.
  function automatic exp_t slice_data(int i, int s);
    exp_t e;
    e.result = 32'h3F80_0000 + ((32'(i) ^ 32'd2) << 16) + 32'(s);
    e.status = 5'(((i ^ 2) * 3) + (s * 7) + 1);
    e.ext    = 1'((i + s) & 1);
    e.tag    = 1'((i ^ s ^ 3) & 1);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic r, input logic f);
    exp_t e;
    slice_valid = v;
    out_ready   = r;
    flush       = f;
    for (int i = 0; i < N; i++) begin
      e = slice_data(i, seq[i]);
      slice_result[i*W +: W] = e.result;
      slice_status[i*5 +: 5] = e.status;
      slice_ext[i]           = e.ext;
      slice_tag[i*TW +: TW]  = e.tag;
    end
  endtask

  task automatic run_cycle(input string name, input logic [3:0] v, input logic r,
                           input logic f, input logic [3:0] exp_ready, input logic exp_ov);
    exp_t e;
    drive(v, r, f);
    @(negedge clk);
    chk({name, ":ready"}, 64'(slice_ready), 64'(exp_ready));
    chk({name, ":out_valid"}, 64'(out_valid), 64'(exp_ov));
    chk({name, ":busy"}, 64'(busy), 64'(exp_ov));
    if (exp_ov) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s:scoreboard got empty queue expected a pending result", name);
      end else if (f) begin
        void'(sbq.pop_front());
      end else begin
        e = sbq[0];
        chk({name, ":result"}, 64'(result), 64'(e.result));
        chk({name, ":status"}, 64'(status), 64'(e.status));
        chk({name, ":ext"}, 64'(ext_bit), 64'(e.ext));
        chk({name, ":tag"}, 64'(tag), 64'(e.tag));
        if (r) void'(sbq.pop_front());
      end
    end
    for (int i = 0; i < N; i++) begin
      if (exp_ready[i]) begin
        sbq.push_back(slice_data(i, seq[i]));
        seq[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_outputs_check(input string name);
    chk({name, ":out_valid"}, 64'(out_valid), 64'd0);
    chk({name, ":result"}, 64'(result), 64'd0);
    chk({name, ":status"}, 64'(status), 64'd0);
    chk({name, ":ext"}, 64'(ext_bit), 64'd0);
    chk({name, ":tag"}, 64'(tag), 64'd0);
    chk({name, ":ready"}, 64'(slice_ready), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b1111, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_outputs_check("reset");
`ifdef FPNEW_OUT_ARB_CONFLICT_CNT_EN
    chk("reset:conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
    sbq.delete();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) seq[i] = 0;
    drive(4'b0000, 1'b0, 1'b0);

    //            valid    ordy  flush exp_ready exp_ov
    vecs[0]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0}; // single slice 2
    vecs[1]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1}; // its result appears
    vecs[2]  = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b0}; // pointer sits at 3
    vecs[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1}; // wrap to 0
    vecs[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1};
    vecs[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1};
    vecs[6]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1};
    vecs[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1};
    vecs[8]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1}; // backpressure x3
    vecs[9]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[10] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[11] = '{4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1}; // release: slice 1
    vecs[12] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1}; // search 2,3,0
    vecs[13] = '{4'b1000, 1'b0, 1'b1, 4'b0000, 1'b1}; // flush held result
    vecs[14] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0}; // slice 3 accepted
    vecs[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1};
    vecs[16] = '{4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0}; // flush blocks grant
    vecs[17] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0};
    vecs[18] = '{4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1}; // stalled
    vecs[19] = '{4'b0110, 1'b1, 1'b1, 4'b0000, 1'b1}; // flush beats ready
    vecs[20] = '{4'b0110, 1'b1, 1'b0, 4'b0010, 1'b0}; // pointer still 1
    vecs[21] = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1}; // back-to-back
    vecs[22] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1};
    vecs[23] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0}; // idle

    do_reset();
    for (int k = 0; k < 24; k++) begin
      run_cycle($sformatf("vec%0d", k), vecs[k].valid, vecs[k].ordy, vecs[k].flush,
                vecs[k].exp_ready, vecs[k].exp_ov);
    end

    // Fairness from reset with all slices requesting.
    do_reset();
    run_cycle("rr0", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);
    run_cycle("rr1", 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1);
    run_cycle("rr2", 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1);
    run_cycle("rr3", 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1);
    run_cycle("rr4", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);

    // Asynchronous reset between edges while a result is held.
    #2;
    rst = 1'b1;
    #1;
    reset_outputs_check("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    run_cycle("post_rst0", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);
    run_cycle("post_rst1", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1);

`ifdef FPNEW_OUT_ARB_CONFLICT_CNT_EN
    do_reset();
    run_cycle("cnt0", 4'b0101, 1'b1, 1'b0, 4'b0001, 1'b0);
    run_cycle("cnt1", 4'b0101, 1'b1, 1'b0, 4'b0100, 1'b1);
    run_cycle("cnt2", 4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1);
    run_cycle("cnt3", 4'b0101, 1'b1, 1'b0, 4'b0100, 1'b1);
    run_cycle("cnt4", 4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1);
    chk("conflict_cnt", 64'(conflict_cnt), 64'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpnew_opgroup_out_arbiter.md
Name: fpnew_opgroup_out_arbiter

Overview:
- Output-side stage directly downstream of the per-format opgroup slices.
- Collects result, status, extension bit and tag from NumSlices format slices, each with its own valid/ready handshake.
- Picks one slice per cycle with a round-robin arbiter and registers the winner into a single output stage that feeds the FPU top-level result mux.
- Gives the slices a fair, backpressure-safe drain path with one cycle of latency and full throughput.

Parameters:
- NumSlices, 4, number of upstream format slices (>=1).
- Width, 32, result width in bits (equals the slice result width).
- TagWidth, 1, width of the per-operation tag.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- slice_valid_i  in  NumSlices  per-slice result valid.
- slice_ready_o  out  NumSlices  per-slice result accepted.
- slice_result_i  in  NumSlices*Width  packed results; slice i occupies [i*Width +: Width].
- slice_status_i  in  NumSlices*5  packed status {NV,DZ,OF,UF,NX}, slice i at [i*5 +: 5].
- slice_ext_bit_i  in  NumSlices  per-slice extension bit.
- slice_tag_i  in  NumSlices*TagWidth  packed tags.
- flush_i  in  1  drop the registered result; no acceptance this cycle.
- result_o  out  Width  registered result.
- status_o  out  5  registered status.
- extension_bit_o  out  1  registered extension bit.
- tag_o  out  TagWidth  registered tag.
- out_valid_o  out  1  output stage holds a valid result.
- out_ready_i  in  1  downstream accepts the result.
- busy_o  out  1  result in flight (equals out_valid_o).

Behaviour:
- Reset (async, rst_i=1): out_valid_o=0, result_o=0, status_o=0, extension_bit_o=0, tag_o=0, round-robin pointer rr_q=0.
  - Outputs are held at these values for as long as rst_i is asserted.
  - Reset mid-operation discards the held result; no slice handshake completes in that cycle.
- Stage enable: stage_en = ~out_valid_q | out_ready_i.
- Arbitration (combinational):
  - Grant goes to the first i with slice_valid_i[i]=1, searching from rr_q upward and wrapping at NumSlices-1 -> 0.
  - At most one grant bit is set; the grant is zero when no slice is valid.
- slice_ready_o[i] = grant[i] & stage_en & ~flush_i. Slice-side handshake completes when valid & ready are both 1.
- On a completed handshake, all of the following happen at the next clock edge:
  - The output registers load the granted slice's result, status, ext bit and tag.
  - out_valid_q is set to 1.
  - rr_q becomes (grant_idx+1) mod NumSlices.
- If stage_en=1 and nothing is accepted: out_valid_q is cleared to 0, data registers hold their values, and rr_q is unchanged.
- Backpressure: while out_valid_o=1 and out_ready_i=0, all outputs stay stable and all slice_ready_o are 0.
- Simultaneous downstream accept and new grant: the new result loads in the same edge (no bubble, 1 result/cycle).
- Latency: exactly 1 cycle from the slice handshake to out_valid_o.
- flush_i=1:
  - out_valid_q is cleared at the next edge.
  - No slice is granted in that cycle.
  - rr_q is unchanged.
  - flush_i overrides a simultaneous out_ready_i.
- NumSlices=1: the pointer is a constant 0; the block reduces to a 1-entry pipeline register.
- Slices hold their valid and data until accepted. The block never drops an accepted result except on flush or reset.

Optional Feature:
- Macro FPNEW_OUT_ARB_CONFLICT_CNT_EN.
- Defined:
  - Adds output port conflict_cnt_o (16 bits).
  - The counter increments by 1 each cycle in which at least two slice_valid_i bits are set while stage_en=1, or any slice_valid_i is set while stage_en=0.
  - It saturates at 16'hFFFF, resets to 0 on rst_i, and is unaffected by flush_i.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Single slice: slice 2 valid with result 32'h3F80_0000, status 5'b00001, tag 1, and out_ready_i=1.
  - Expect slice_ready_o=4'b0100 in that cycle.
  - Next cycle expect out_valid_o=1, result_o=32'h3F80_0000, status_o=5'b00001, tag_o=1, and rr_q=3.
- Round-robin fairness: all four slices held valid with out_ready_i=1 from reset.
  - Expect grants in order 0,1,2,3,0 on consecutive cycles and out_valid_o=1 on every cycle from cycle 1.
- Backpressure: out_ready_i=0 for 3 cycles with a result held and slices 0 and1 valid.
  - Expect slice_ready_o=0 and outputs stable throughout.
  - On out_ready_i=1, expect slice 1 granted (rr_q=1 after the prior grant of 0).
- Flush: flush_i=1 while out_valid_o=1, slice 3 valid and out_ready_i=0.
  - Expect slice_ready_o=0 and out_valid_o=0 next cycle.
  - Slice 3 is accepted in the following cycle.
- Async reset mid-stream: assert rst_i between clock edges while out_valid_o=1.
  - Expect out_valid_o=0 and result_o=0 immediately.
  - After deassertion, the first grant goes to slice 0.
- With FPNEW_OUT_ARB_CONFLICT_CNT_EN: slices 0 and 2 valid with out_ready_i=1 for 5 cycles.
  - Expect conflict_cnt_o=5 after the fifth edge.
